// File: rtl/riscv_pkg.sv
// Shared RISC-V definitions: immediate source selectors and encoder result payload.
package riscv_pkg;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned IMMSRC_W = 3;

    typedef logic [IMMSRC_W-1:0] immsrc_t;

    localparam immsrc_t IMM_I  = 3'b001;
    localparam immsrc_t IMM_S  = 3'b010;
    localparam immsrc_t IMM_B  = 3'b011;
    localparam immsrc_t IMM_J  = 3'b100;
    localparam immsrc_t IMM_U  = 3'b110;
    localparam immsrc_t IMM_SH = 3'b111;

    // Packed instruction plus round-trip check flags
    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic            err_range;
        logic            err_align;
        logic            err_src;
    } enc_res_t;

endpackage : riscv_pkg

// File: rtl/imm_pack.sv
// Combinational immediate packer: scatters imm into the selected format's
// instruction fields over a template and flags values the decoder cannot
// reproduce.
module imm_pack
    import riscv_pkg::*;
#(
    parameter bit ZERO_ON_ERR = 1'b0
) (
    input  logic [XLEN-1:0] imm,
    input  immsrc_t         immsrc,
    input  logic [XLEN-1:0] tmpl,
    output logic [XLEN-1:0] instr_c,
    output logic            err_range_c,
    output logic            err_align_c,
    output logic            err_src_c
);

    logic [XLEN-1:0] fld;

    // Range / alignment / selector checks; a bit range is representable when it is all-equal
    always_comb begin
        err_range_c = 1'b0;
        err_align_c = 1'b0;
        err_src_c   = 1'b0;
        case (immsrc)
            IMM_I, IMM_S: err_range_c = !((&imm[31:11]) || !(|imm[31:11]));
            IMM_B: begin
                err_range_c = !((&imm[31:12]) || !(|imm[31:12]));
                err_align_c = imm[0];
            end
            IMM_J: begin
                err_range_c = !((&imm[31:20]) || !(|imm[31:20]));
                err_align_c = imm[0];
            end
            IMM_U:   err_range_c = |imm[11:0];
            IMM_SH:  err_range_c = !((&imm[31:4]) || !(|imm[31:4]));
            default: err_src_c = 1'b1;
        endcase
    end

    // Field scatter; an unsupported selector leaves the template untouched
    always_comb begin
        instr_c = tmpl;
        fld     = (ZERO_ON_ERR && (err_range_c || err_align_c)) ? '0 : imm;
        case (immsrc)
            IMM_I: instr_c[31:20] = fld[11:0];
            IMM_S: begin
                instr_c[31:25] = fld[11:5];
                instr_c[11:7]  = fld[4:0];
            end
            IMM_B: begin
                instr_c[31]    = fld[12];
                instr_c[7]     = fld[11];
                instr_c[30:25] = fld[10:5];
                instr_c[11:8]  = fld[4:1];
            end
            IMM_J: begin
                instr_c[31]    = fld[20];
                instr_c[19:12] = fld[19:12];
                instr_c[20]    = fld[11];
                instr_c[30:21] = fld[10:1];
            end
            IMM_U:   instr_c[31:12] = fld[31:12];
            IMM_SH:  instr_c[24:20] = fld[4:0];
            default: instr_c = tmpl;
        endcase
    end

endmodule : imm_pack

// File: rtl/imm_encoder.sv
// Two-stage valid/ready immediate encoder with saturating error-beat counter.
module imm_encoder
    import riscv_pkg::*;
#(
    parameter int unsigned CNT_W       = 8,
    parameter bit          ZERO_ON_ERR = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [XLEN-1:0]  in_imm,
    input  immsrc_t          in_immsrc,
    input  logic [XLEN-1:0]  in_tmpl,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_instr,
    output logic             out_err_range,
    output logic             out_err_align,
    output logic             out_err_src,
    output logic [CNT_W-1:0] err_cnt,
    input  logic             err_cnt_clr
);

    enc_res_t pack_c;
    enc_res_t s1_q;
    enc_res_t s2_q;
    logic     s1_valid;
    logic     s2_valid;
    logic     s1_adv;
    logic     s2_adv;
    logic     err_beat;

    imm_pack #(
        .ZERO_ON_ERR(ZERO_ON_ERR)
    ) u_pack (
        .imm        (in_imm),
        .immsrc     (in_immsrc),
        .tmpl       (in_tmpl),
        .instr_c    (pack_c.instr),
        .err_range_c(pack_c.err_range),
        .err_align_c(pack_c.err_align),
        .err_src_c  (pack_c.err_src)
    );

    // Handshake: a stage advances when the next one is empty or draining
    assign s2_adv   = !s2_valid || out_ready;
    assign s1_adv   = s1_valid && s2_adv;
    assign in_ready = !s1_valid || s2_adv;
    assign err_beat = s2_valid && out_ready
                      && (s2_q.err_range || s2_q.err_align || s2_q.err_src);

    // Stage 1: capture the packed result of an accepted request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_q     <= '0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) s1_q <= pack_c;
        end
    end

    // Stage 2: output register, holds while stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_q     <= '0;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_adv) s2_q <= s1_q;
        end
    end

    // Error-beat counter: clear wins, saturates at all-ones
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= '0;
        end else if (err_cnt_clr) begin
            err_cnt <= '0;
        end else if (err_beat && (err_cnt != {CNT_W{1'b1}})) begin
            err_cnt <= err_cnt + CNT_W'(1);
        end
    end

    assign out_valid     = s2_valid;
    assign out_instr     = s2_q.instr;
    assign out_err_range = s2_q.err_range;
    assign out_err_align = s2_q.err_align;
    assign out_err_src   = s2_q.err_src;

endmodule : imm_encoder

// File: tb/tb_imm_encoder.sv
// Self-checking bench for imm_encoder: directed cases, backpressure, random
// traffic against an arithmetic reference model, reset and counter saturation.
module tb_imm_encoder;

    localparam int CNT_W = 8;
    localparam bit ZOE   = 1'b0;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_imm;
    logic [2:0]  in_immsrc;
    logic [31:0] in_tmpl;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic        out_err_range;
    logic        out_err_align;
    logic        out_err_src;
    logic [7:0]  err_cnt;
    logic        err_cnt_clr;

    int n_cmp  = 0;
    int n_fail = 0;
    int exp_cnt = 0;

    typedef struct packed {
        logic [31:0] instr;
        logic        r;
        logic        a;
        logic        s;
        logic [31:0] imm;
        logic [2:0]  src;
    } exp_t;

    imm_encoder #(.CNT_W(CNT_W), .ZERO_ON_ERR(ZOE)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_imm       (in_imm),
        .in_immsrc    (in_immsrc),
        .in_tmpl      (in_tmpl),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_instr    (out_instr),
        .out_err_range(out_err_range),
        .out_err_align(out_err_align),
        .out_err_src  (out_err_src),
        .err_cnt      (err_cnt),
        .err_cnt_clr  (err_cnt_clr)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference encoder: signed ranges and shift/mask arithmetic
    function automatic exp_t model(input logic [31:0] imm, input logic [2:0] src,
                                   input logic [31:0] tmpl);
        exp_t        e;
        int          v;
        logic [31:0] mask;
        logic [31:0] fld;
        bit          known;
        v = $signed(imm);
        known = 1'b1;
        mask = 32'h0;
        fld = 32'h0;
        e.r = 1'b0;
        e.a = 1'b0;
        e.s = 1'b0;
        e.imm = imm;
        e.src = src;
        case (src)
            3'd1: begin
                e.r = (v < -2048) || (v > 2047);
                mask = 32'hFFF0_0000;
                fld = (imm & 32'hFFF) << 20;
            end
            3'd2: begin
                e.r = (v < -2048) || (v > 2047);
                mask = 32'hFE00_0F80;
                fld = (((imm >> 5) & 32'h7F) << 25) | ((imm & 32'h1F) << 7);
            end
            3'd3: begin
                e.r = (v < -4096) || (v > 4095);
                e.a = imm[0];
                mask = 32'hFE00_0F80;
                fld = (((imm >> 12) & 32'h1) << 31) | (((imm >> 11) & 32'h1) << 7)
                    | (((imm >> 5) & 32'h3F) << 25) | (((imm >> 1) & 32'hF) << 8);
            end
            3'd4: begin
                e.r = (v < -(1 << 20)) || (v > (1 << 20) - 1);
                e.a = imm[0];
                mask = 32'hFFFF_F000;
                fld = (((imm >> 20) & 32'h1) << 31) | (imm & 32'h000F_F000)
                    | (((imm >> 11) & 32'h1) << 20) | (((imm >> 1) & 32'h3FF) << 21);
            end
            3'd6: begin
                e.r = (imm % 4096) != 0;
                mask = 32'hFFFF_F000;
                fld = imm & 32'hFFFF_F000;
            end
            3'd7: begin
                e.r = (v < -16) || (v > 15);
                mask = 32'h01F0_0000;
                fld = (imm & 32'h1F) << 20;
            end
            default: known = 1'b0;
        endcase
        if (!known) begin
            e.s = 1'b1;
            e.instr = tmpl;
        end else begin
            if (ZOE && (e.r || e.a)) fld = 32'h0;
            e.instr = (tmpl & ~mask) | (fld & mask);
        end
        return e;
    endfunction

    // Core-side immediate sign-extender used for the round-trip check
    function automatic logic [31:0] decode(input logic [31:0] ins, input logic [2:0] src);
        case (src)
            3'd1: return 32'($signed(ins) >>> 20);
            3'd2: return {{20{ins[31]}}, ins[31:25], ins[11:7]};
            3'd3: return {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            3'd4: return {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
            3'd6: return {ins[31:12], 12'h000};
            3'd7: return {{27{ins[24]}}, ins[24:20]};
            default: return 32'h0;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Single beat with out_ready high; returns result and accept-to-valid latency
    task automatic xfer(input logic [31:0] imm, input logic [2:0] src, input logic [31:0] tmpl,
                        output logic [31:0] ins, output logic r, output logic a, output logic s,
                        output int lat, output bit ok);
        int w;
        in_imm = imm;
        in_immsrc = src;
        in_tmpl = tmpl;
        in_valid = 1'b1;
        out_ready = 1'b1;
        ok = 1'b0;
        ins = 32'h0;
        r = 1'b0;
        a = 1'b0;
        s = 1'b0;
        w = 0;
        #1;
        while (!in_ready && w < 20) begin
            step();
            w++;
        end
        step();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            step();
            lat++;
        end
        if (out_valid) begin
            ok = 1'b1;
            ins = out_instr;
            r = out_err_range;
            a = out_err_align;
            s = out_err_src;
            step();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        err_cnt_clr = 1'b0;
        in_imm = '0;
        in_immsrc = '0;
        in_tmpl = '0;
        repeat (3) step();
        n_cmp++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_cmp++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        n_cmp++;
        if (out_instr !== 32'h0) begin n_fail++; $display("FAIL reset_out_instr: got %h want 0", out_instr); end
        n_cmp++;
        if ({out_err_range, out_err_align, out_err_src} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_flags: got %b want 000", {out_err_range, out_err_align, out_err_src});
        end
        n_cmp++;
        if (err_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_err_cnt: got %0d want 0", err_cnt); end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_directed();
        logic [31:0] v_imm  [10] = '{32'hFFFF_FFFF, 32'h0000_0800, 32'h0000_1000, 32'h0000_0005,
                                     32'd5, 32'd16, 32'h1234_5000, 32'h0000_0123,
                                     32'h0000_0800, 32'hFFFF_F800};
        logic [2:0]  v_src  [10] = '{3'd1, 3'd3, 3'd3, 3'd3, 3'd7, 3'd7, 3'd6, 3'd5, 3'd4, 3'd2};
        logic [31:0] v_tmpl [10] = '{32'h13, 32'h63, 32'h63, 32'h63, 32'h4000_5013, 32'h4000_5013,
                                     32'h37, 32'hDEAD_BEEF, 32'h6F, 32'h23};
        logic [31:0] v_out  [10] = '{32'hFFF0_0013, 32'h0000_00E3, 32'h8000_0063, 32'h0000_0263,
                                     32'h4050_5013, 32'h4100_5013, 32'h1234_5037, 32'hDEAD_BEEF,
                                     32'h0010_006F, 32'h8000_0023};
        logic [2:0]  v_flg  [10] = '{3'b000, 3'b000, 3'b100, 3'b010, 3'b000, 3'b100, 3'b000,
                                     3'b001, 3'b000, 3'b000};
        logic [31:0] ins;
        logic        r, a, s;
        int          lat;
        bit          ok;
        for (int i = 0; i < 10; i++) begin
            xfer(v_imm[i], v_src[i], v_tmpl[i], ins, r, a, s, lat, ok);
            if (v_flg[i] != 3'b000 && exp_cnt < 255) exp_cnt++;
            n_cmp++;
            if (!ok) begin n_fail++; $display("FAIL dir%0d_timeout: no out_valid within 20 cycles", i); end
            n_cmp++;
            if (lat != 2) begin n_fail++; $display("FAIL dir%0d_latency: got %0d want 2", i, lat); end
            n_cmp++;
            if (ins !== v_out[i]) begin n_fail++; $display("FAIL dir%0d_instr: got %h want %h", i, ins, v_out[i]); end
            n_cmp++;
            if ({r, a, s} !== v_flg[i]) begin n_fail++; $display("FAIL dir%0d_flags: got %b want %b", i, {r, a, s}, v_flg[i]); end
            n_cmp++;
            if (err_cnt !== 8'(exp_cnt)) begin n_fail++; $display("FAIL dir%0d_err_cnt: got %0d want %0d", i, err_cnt, exp_cnt); end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] b_imm [3] = '{32'd1, 32'hFFFF_FFF0, 32'd100};
        exp_t        q[$];
        exp_t        e;
        int          sent, got, acc4;
        logic [31:0] held;
        sent = 0;
        got = 0;
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_immsrc = 3'd1;
        in_tmpl = 32'h0000_0093;
        in_imm = b_imm[0];
        held = 32'h0;
        for (int c = 0; c < 4; c++) begin
            #1;
            if (c == 3) begin
                n_cmp++;
                if (out_instr !== held) begin n_fail++; $display("FAIL bp_hold: got %h want %h", out_instr, held); end
            end
            if (c == 2) held = out_instr;
            if (in_valid && in_ready) begin
                q.push_back(model(in_imm, in_immsrc, in_tmpl));
                sent++;
            end
            step();
            if (sent < 3) in_imm = b_imm[sent];
        end
        acc4 = sent;
        #1;
        n_cmp++;
        if (acc4 != 2) begin n_fail++; $display("FAIL bp_accepted: got %0d want 2", acc4); end
        n_cmp++;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready: got %b want 0", in_ready); end
        out_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (in_valid && in_ready) begin
                q.push_back(model(in_imm, in_immsrc, in_tmpl));
                sent++;
            end
            if (out_valid) begin
                got++;
                if (q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL bp_extra: unexpected beat %h", out_instr);
                end else begin
                    e = q.pop_front();
                    n_cmp++;
                    if (out_instr !== e.instr) begin n_fail++; $display("FAIL bp_order: got %h want %h", out_instr, e.instr); end
                end
            end
            step();
            if (sent >= 3) in_valid = 1'b0;
            else in_imm = b_imm[sent];
        end
        n_cmp++;
        if (got != 3) begin n_fail++; $display("FAIL bp_count: got %0d beats want 3", got); end
    endtask

    task automatic test_random();
        exp_t        q[$];
        exp_t        e;
        bit          accepted, stalled;
        logic [31:0] p_instr;
        logic [2:0]  p_flg;
        int          k;
        logic [31:0] v;
        accepted = 1'b0;
        stalled = 1'b0;
        p_instr = '0;
        p_flg = '0;
        in_valid = 1'b0;
        for (int c = 0; c < 600; c++) begin
            if (!in_valid || accepted) begin
                if ($urandom_range(0, 9) < 7) begin
                    in_valid = 1'b1;
                    in_immsrc = 3'($urandom_range(0, 7));
                    in_tmpl = $urandom;
                    case ($urandom_range(0, 2))
                        0: in_imm = $urandom;
                        1: begin
                            k = $urandom_range(3, 21);
                            v = $urandom & ((32'h1 << k) - 32'h1);
                            in_imm = ($urandom_range(0, 1) == 1) ? v : ~v;
                        end
                        default: in_imm = $urandom & 32'hFFFF_F000;
                    endcase
                    if ($urandom_range(0, 3) != 0) in_imm[0] = 1'b0;
                end else begin
                    in_valid = 1'b0;
                end
            end
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            accepted = in_valid && in_ready;
            if (accepted) q.push_back(model(in_imm, in_immsrc, in_tmpl));
            if (stalled) begin
                n_cmp++;
                if (!out_valid || out_instr !== p_instr
                    || {out_err_range, out_err_align, out_err_src} !== p_flg) begin
                    n_fail++;
                    $display("FAIL rnd_stable: got v=%b %h want v=1 %h", out_valid, out_instr, p_instr);
                end
            end
            if (out_valid && out_ready) begin
                n_cmp++;
                if (q.size() == 0) begin
                    n_fail++;
                    $display("FAIL rnd_extra: unexpected beat %h", out_instr);
                end else begin
                    e = q.pop_front();
                    if (out_instr !== e.instr || {out_err_range, out_err_align, out_err_src} !== {e.r, e.a, e.s}) begin
                        n_fail++;
                        $display("FAIL rnd_beat: got %h/%b want %h/%b (imm %h src %0d)", out_instr,
                                 {out_err_range, out_err_align, out_err_src}, e.instr, {e.r, e.a, e.s}, e.imm, e.src);
                    end
                    if (!e.r && !e.a && !e.s) begin
                        n_cmp++;
                        if (decode(out_instr, e.src) !== e.imm) begin
                            n_fail++;
                            $display("FAIL rnd_roundtrip: got %h want %h (src %0d)", decode(out_instr, e.src), e.imm, e.src);
                        end
                    end
                    if ((e.r || e.a || e.s) && exp_cnt < 255) exp_cnt++;
                end
            end
            stalled = out_valid && !out_ready;
            p_instr = out_instr;
            p_flg = {out_err_range, out_err_align, out_err_src};
            step();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            #1;
            if (out_valid) begin
                n_cmp++;
                if (q.size() == 0) begin
                    n_fail++;
                    $display("FAIL rnd_drain_extra: unexpected beat %h", out_instr);
                end else begin
                    e = q.pop_front();
                    if (out_instr !== e.instr) begin n_fail++; $display("FAIL rnd_drain: got %h want %h", out_instr, e.instr); end
                    if ((e.r || e.a || e.s) && exp_cnt < 255) exp_cnt++;
                end
            end
            step();
        end
        n_cmp++;
        if (q.size() != 0) begin n_fail++; $display("FAIL rnd_lost: got %0d pending want 0", q.size()); end
        n_cmp++;
        if (err_cnt !== 8'(exp_cnt)) begin n_fail++; $display("FAIL rnd_err_cnt: got %0d want %0d", err_cnt, exp_cnt); end
    endtask

    task automatic test_reset_midflight();
        int w;
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_immsrc = 3'd0;
        in_imm = 32'h55;
        in_tmpl = 32'h1234_5678;
        w = 0;
        #1;
        while (in_ready && w < 10) begin
            step();
            w++;
        end
        n_cmp++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_fill: got v=%b rdy=%b want v=1 rdy=0", out_valid, in_ready);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_out_valid: got %b want 0", out_valid); end
        n_cmp++;
        if (err_cnt !== 8'd0) begin n_fail++; $display("FAIL mid_err_cnt: got %0d want 0", err_cnt); end
        n_cmp++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL mid_in_ready: got %b want 1", in_ready); end
        in_valid = 1'b0;
        exp_cnt = 0;
        step();
        rst_n = 1'b1;
        out_ready = 1'b1;
        step();
        step();
        n_cmp++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_dropped: got out_valid %b want 0", out_valid); end
    endtask

    task automatic test_saturation();
        int beats, c;
        beats = 0;
        c = 0;
        out_ready = 1'b1;
        in_valid = 1'b1;
        in_immsrc = 3'd5;
        in_imm = 32'h0;
        in_tmpl = 32'hA5A5_A5A5;
        #1;
        while (beats < 300 && c < 400) begin
            if (out_valid && out_ready) beats++;
            step();
            c++;
        end
        n_cmp++;
        if (beats != 300) begin n_fail++; $display("FAIL sat_beats: got %0d want 300", beats); end
        n_cmp++;
        if (err_cnt !== 8'd255) begin n_fail++; $display("FAIL sat_err_cnt: got %0d want 255", err_cnt); end
        err_cnt_clr = 1'b1;
        n_cmp++;
        if (out_valid !== 1'b1) begin n_fail++; $display("FAIL sat_clr_beat: got out_valid %b want 1", out_valid); end
        step();
        err_cnt_clr = 1'b0;
        in_valid = 1'b0;
        n_cmp++;
        if (err_cnt !== 8'd0) begin n_fail++; $display("FAIL sat_clr: got %0d want 0", err_cnt); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_random();
        test_reset_midflight();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_imm_encoder
